// File: rtl/mul16_pkg.sv
// mul16_pkg: shared state encoding and default geometry for the mul16 engine.
package mul16_pkg;
  typedef enum logic [3:0] {IDLE, ARM, RD0, RD1, RD2, RD3, MUL, WR0, WR1, WR2, WR3, NEXT, DONE} state_t;
  localparam int NUM_PAIRS_DEF = 16;
  localparam int SRC_BASE_DEF = 0;
  localparam int DST_BASE_DEF = 64;
endpackage

// File: rtl/booth_mul16.sv
// booth_mul16: 16-cycle radix-2 Booth signed multiplier, p = a * b.
module booth_mul16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p,
  output logic        last
);
  // acc carries a guard bit so subtracting -32768 cannot overflow
  logic [16:0] acc_q, acc_d, sum;
  logic [15:0] m_q, m_d, q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [3:0]  cnt_q, cnt_d;
  always_comb begin
    sum = acc_q + ({q_q[0], qm1_q} == 2'b01 ? {m_q[15], m_q} :
                   {q_q[0], qm1_q} == 2'b10 ? -{m_q[15], m_q} : 17'd0);
    acc_d = acc_q;
    m_d = m_q;
    q_d = q_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = '0;
      m_d = a;
      q_d = b;
      qm1_d = 1'b0;
      cnt_d = 4'd15;
    end else if (step) begin
      acc_d = {sum[16], sum[16:1]};
      q_d = {sum[0], q_q[15:1]};
      qm1_d = q_q[0];
      cnt_d = cnt_q - 4'd1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc_q <= '0;
      m_q <= '0;
      q_q <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      m_q <= m_d;
      q_q <= q_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
    end
  assign p = {acc_q[15:0], q_q};
  assign last = cnt_q == 4'd0;
endmodule

// File: rtl/mul16_engine.sv
// mul16_engine: walks operand pairs in data memory, multiplies each, writes 32-bit products back.
module mul16_engine
  import mul16_pkg::*;
#(
  parameter int NUM_PAIRS = NUM_PAIRS_DEF,
  parameter int SRC_BASE = SRC_BASE_DEF,
  parameter int DST_BASE = DST_BASE_DEF,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    mem_rd_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic          busy,
  output logic          done
);
  localparam int PW = $clog2(NUM_PAIRS + 1);
  state_t        state_q, state_d;
  logic [PW-1:0] pair_q, pair_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [7:0]    bhi_q, bhi_d, blo_q, blo_d, ahi_q, ahi_d;
  logic          load, step, last, fin;
  logic [31:0]   p;
  logic [AW-1:0] off;
  logic [1:0]    ridx, widx;
  assign off = AW'(pair_q) << 2;
  assign ridx = 2'(state_q - RD0);
  assign widx = 2'(state_q - WR0);
  assign fin = pair_q == PW'(NUM_PAIRS - 1);
  // A.lo goes straight from the memory bus into the multiplier on RD3
  booth_mul16 u_booth (
    .clk(clk), .reset(reset), .load(load), .step(step),
    .a({ahi_q, mem_rd_data}), .b({bhi_q, blo_q}), .p(p), .last(last)
  );
  always_comb begin
    state_d = state_q;
    pair_d = pair_q;
    busy_d = busy_q;
    done_d = done_q;
    bhi_d = bhi_q;
    blo_d = blo_q;
    ahi_d = ahi_q;
    load = 1'b0;
    step = 1'b0;
    mem_addr = '0;
    mem_wr_en = 1'b0;
    mem_wr_data = 8'(p >> {~widx, 3'b000});
    case (state_q)
      IDLE: state_d = start ? ARM : IDLE;
      ARM: if (!start) begin
        state_d = RD0;
        busy_d = 1'b1;
        done_d = 1'b0;
        pair_d = '0;
      end
      RD0, RD1, RD2, RD3: begin
        mem_addr = AW'(SRC_BASE) + off + AW'(ridx);
        bhi_d = state_q == RD0 ? mem_rd_data : bhi_q;
        blo_d = state_q == RD1 ? mem_rd_data : blo_q;
        ahi_d = state_q == RD2 ? mem_rd_data : ahi_q;
        load = state_q == RD3;
        state_d = state_t'(state_q + 4'd1);
      end
      MUL: begin
        step = 1'b1;
        state_d = last ? WR0 : MUL;
      end
      WR0, WR1, WR2, WR3: begin
        mem_wr_en = 1'b1;
        mem_addr = AW'(DST_BASE) + off + AW'(widx);
        state_d = state_t'(state_q + 4'd1);
      end
      NEXT: begin
        pair_d = pair_q + PW'(1);
        state_d = fin ? DONE : RD0;
        busy_d = !fin;
        done_d = fin;
      end
      DONE: state_d = start ? ARM : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      pair_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bhi_q <= '0;
      blo_q <= '0;
      ahi_q <= '0;
    end else begin
      state_q <= state_d;
      pair_q <= pair_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bhi_q <= bhi_d;
      blo_q <= blo_d;
      ahi_q <= ahi_d;
    end
  assign busy = busy_q;
  assign done = done_q;
endmodule
